// File: rtl/iddr_align_if.sv
// Bundle between the IDDR word-alignment controller and its surroundings:
// IDDR bit pairs and restart come in, IDDR control and aligned words go out.
interface iddr_align_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Q1;
  logic             Q2;
  logic             START;
  logic             IDDR_CE;
  logic             IDDR_SR;
  logic [WIDTH-1:0] DOUT;
  logic             DVALID;
  logic             LOCKED;
  logic             TRAIN_ERR;
  logic [3:0]       SLIP_CNT;

  // Side that feeds the controller and consumes its outputs
  modport master (
    output Q1, Q2, START,
    input  IDDR_CE, IDDR_SR, DOUT, DVALID, LOCKED, TRAIN_ERR, SLIP_CNT
  );

  // Controller side
  modport slave (
    input  Q1, Q2, START,
    output IDDR_CE, IDDR_SR, DOUT, DVALID, LOCKED, TRAIN_ERR, SLIP_CNT
  );
endinterface

// File: rtl/iddr_align_ctrl.sv
// IDDR word-alignment controller: holds the IDDR in reset, flushes the
// deserializer, slips the word boundary until the training word is seen
// LOCK_COUNT times in a row, then streams aligned words.
module iddr_align_ctrl #(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'hB5),
  parameter int unsigned      RST_CYCLES    = 16,
  parameter int unsigned      LOCK_COUNT    = 4
) (
  input  logic        C,
  input  logic        R,
  iddr_align_if.slave bus
);

  localparam int unsigned SH_W  = 2 * WIDTH;
  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned PH_W  = $clog2(HALF);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned MC_W  = 4;
  localparam int unsigned SL_W  = 4;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_FLUSH,
    ST_TRAIN,
    ST_SETTLE,
    ST_LOCK,
    ST_FAIL
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PH_W-1:0]   ph;
  logic [SH_W-1:0]   sh;
  logic [MC_W-1:0]   match_cnt;
  logic [SL_W-1:0]   slip_cnt;
  logic              sr;
  logic              ce;
  logic [WIDTH-1:0]  dout;
  logic              dvalid;
  logic              locked;
  logic              train_err;

  logic [WIDTH-1:0]  cand;
  logic              boundary;

  // Candidate word at the current slip offset and word-boundary detect
  always_comb begin
    cand     = WIDTH'(sh >> slip_cnt);
    boundary = ce && (ph == PH_W'(HALF - 1));
  end

  // Sequencer, deserializer and registered outputs; START overrides everything
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      ph        <= '0;
      sh        <= '0;
      match_cnt <= '0;
      slip_cnt  <= '0;
      sr        <= 1'b1;
      ce        <= 1'b0;
      dout      <= '0;
      dvalid    <= 1'b0;
      locked    <= 1'b0;
      train_err <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      if (ce) begin
        sh <= {sh[SH_W-3:0], bus.Q1, bus.Q2};
        ph <= (ph == PH_W'(HALF - 1)) ? '0 : ph + 1'b1;
      end

      if (bus.START) begin
        state     <= ST_HOLD;
        cnt       <= '0;
        ph        <= '0;
        match_cnt <= '0;
        slip_cnt  <= '0;
        locked    <= 1'b0;
        train_err <= 1'b0;
        sr        <= 1'b1;
        ce        <= 1'b0;
      end else begin
        case (state)
          ST_HOLD: begin
            if (cnt == CNT_W'(RST_CYCLES - 1)) begin
              state <= ST_FLUSH;
              cnt   <= '0;
              sr    <= 1'b0;
              ce    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_FLUSH: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= ST_TRAIN;
              cnt   <= '0;
              ph    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_TRAIN: begin
            if (boundary) begin
              if (cand == TRAIN_PATTERN) begin
                match_cnt <= match_cnt + 1'b1;
                if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                  state  <= ST_LOCK;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
                if (slip_cnt == SL_W'(WIDTH - 1)) begin
                  state     <= ST_FAIL;
                  train_err <= 1'b1;
                end else begin
                  slip_cnt <= slip_cnt + 1'b1;
                  state    <= ST_SETTLE;
                end
              end
            end
          end
          ST_SETTLE: begin
            // The word straddling the old/new offset is thrown away
            if (boundary) state <= ST_TRAIN;
          end
          ST_LOCK: begin
            if (boundary) begin
              dout   <= cand;
              dvalid <= 1'b1;
            end
          end
          ST_FAIL: begin
          end
          default: state <= ST_HOLD;
        endcase
      end
    end
  end

  assign bus.IDDR_SR   = sr;
  assign bus.IDDR_CE   = ce;
  assign bus.DOUT      = dout;
  assign bus.DVALID    = dvalid;
  assign bus.LOCKED    = locked;
  assign bus.TRAIN_ERR = train_err;
  assign bus.SLIP_CNT  = slip_cnt;

endmodule
